// File: rtl/hpu_job_sched_if.sv
// Control/status bundle between the job-posting side and hpu_job_sched.
// timeout_flag is present only when HPU_SCHED_TIMEOUT_EN is defined.
interface hpu_job_sched_if #(
    parameter int BATCH_W = 16,
    parameter int MAT_W   = 7
);
    logic               start;
    logic               abort;
    logic               cfg_load_mat;
    logic [MAT_W-1:0]   cfg_mat_words;
    logic [BATCH_W-1:0] cfg_batches;
    logic               mat_beat;
    logic               src_fin;
    logic               dst_last_hs;
    logic               matw;
    logic               run;
    logic               last;
    logic               busy;
    logic               done;
    logic               err;
    logic [BATCH_W-1:0] src_cnt;
    logic [BATCH_W-1:0] out_cnt;
`ifdef HPU_SCHED_TIMEOUT_EN
    logic               timeout_flag;
`endif

    modport master (
        output start, abort, cfg_load_mat, cfg_mat_words, cfg_batches,
               mat_beat, src_fin, dst_last_hs,
        input  matw, run, last, busy, done, err, src_cnt, out_cnt
`ifdef HPU_SCHED_TIMEOUT_EN
        , input timeout_flag
`endif
    );

    modport slave (
        input  start, abort, cfg_load_mat, cfg_mat_words, cfg_batches,
               mat_beat, src_fin, dst_last_hs,
        output matw, run, last, busy, done, err, src_cnt, out_cnt
`ifdef HPU_SCHED_TIMEOUT_EN
        , output timeout_flag
`endif
    );
endinterface

// File: rtl/hpu_job_sched.sv
// Job sequencer driving matw/run/last for the HPU stream datapath.
// Optional progress watchdog enabled by HPU_SCHED_TIMEOUT_EN.
module hpu_job_sched #(
    parameter int BATCH_W = 16,
    parameter int MAT_W   = 7,
    parameter int GAP_CYC = 2
`ifdef HPU_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 65535
`endif
) (
    input  logic           AXIS_ACLK,
    input  logic           AXIS_ARESETN,
    hpu_job_sched_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_RUN, S_DONE} state_t;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t             r_state, w_state_nxt;
    logic [MAT_W-1:0]   r_mat_words, r_beat;
    logic [BATCH_W-1:0] r_batches, r_src_cnt, r_out_cnt;
    logic [GW-1:0]      r_gap;
    logic               r_err, w_err_nxt, w_accept, w_kill, w_in_run;

`ifdef HPU_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] r_wd;
    logic          r_tmo, w_timeout, w_progress;

    assign w_progress = bus.mat_beat | bus.src_fin | bus.dst_last_hs;
    // Fires on the cycle the idle count would reach TIMEOUT_CYC.
    assign w_timeout  = (r_state == S_LOAD || r_state == S_RUN) && !w_progress &&
                        (r_wd == WW'(TIMEOUT_CYC - 1));
    assign w_kill     = bus.abort | w_timeout;
`else
    assign w_kill     = bus.abort;
`endif

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_accept    = 1'b0;
        if (r_state != S_IDLE && w_kill) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
        end else begin
            // A start while busy is reported but never disturbs the job.
            if (r_state != S_IDLE && bus.start) w_err_nxt = 1'b1;
            case (r_state)
                S_IDLE: if (bus.start && !bus.abort) begin
                    if (bus.cfg_batches == '0) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = (bus.cfg_load_mat && bus.cfg_mat_words != '0) ? S_LOAD : S_GAP;
                    end
                end
                S_LOAD: if (bus.mat_beat && r_beat == r_mat_words - 1'b1) w_state_nxt = S_GAP;
                S_GAP:  if (r_gap == GW'(GAP_CYC - 1)) w_state_nxt = S_RUN;
                S_RUN:  if (bus.dst_last_hs && r_out_cnt == r_batches - 1'b1) w_state_nxt = S_DONE;
                S_DONE: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_in_run = (r_state == S_RUN) && !w_kill;

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_mat_words <= '0;
            r_batches   <= '0;
            r_beat      <= '0;
            r_src_cnt   <= '0;
            r_out_cnt   <= '0;
            r_gap       <= '0;
        end else begin
            if (w_accept) begin
                r_mat_words <= bus.cfg_mat_words;
                r_batches   <= bus.cfg_batches;
                r_beat      <= '0;
                r_src_cnt   <= '0;
                r_out_cnt   <= '0;
            end else begin
                if (r_state == S_LOAD && bus.mat_beat) r_beat <= r_beat + 1'b1;
                if (w_in_run && bus.src_fin && r_src_cnt < r_batches)
                    r_src_cnt <= r_src_cnt + 1'b1;
                if (w_in_run && bus.dst_last_hs && r_out_cnt < r_batches)
                    r_out_cnt <= r_out_cnt + 1'b1;
            end
            r_gap <= (r_state == S_GAP) ? r_gap + 1'b1 : '0;
        end
    end

`ifdef HPU_SCHED_TIMEOUT_EN
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_wd  <= '0;
            r_tmo <= 1'b0;
        end else begin
            if (w_progress || w_state_nxt != r_state) r_wd <= '0;
            else if (r_state == S_LOAD || r_state == S_RUN) r_wd <= r_wd + 1'b1;
            if (w_accept)       r_tmo <= 1'b0;
            else if (w_timeout) r_tmo <= 1'b1;
        end
    end
    assign bus.timeout_flag = r_tmo;
`endif

    // last covers both the single-batch case and the final-batch window.
    assign bus.matw    = (r_state == S_LOAD);
    assign bus.run     = (r_state == S_RUN);
    assign bus.last    = (r_state == S_RUN) && (r_src_cnt >= r_batches - 1'b1);
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.err     = r_err;
    assign bus.src_cnt = r_src_cnt;
    assign bus.out_cnt = r_out_cnt;
endmodule

// File: tb/tb_hpu_job_sched.sv
// Directed bench for hpu_job_sched with a job-level reference model.
`timescale 1ns/1ps
module tb_hpu_job_sched;
    localparam int BATCH_W = 16;
    localparam int MAT_W   = 7;
    localparam int GAP_CYC = 2;
`ifdef HPU_SCHED_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 50;
`endif
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_GAP = 2, PH_RUN = 3, PH_DONE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   cmp_en = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   mcyc;

    always #5 clk = ~clk;

    hpu_job_sched_if #(.BATCH_W(BATCH_W), .MAT_W(MAT_W)) bus ();

    hpu_job_sched #(
        .BATCH_W(BATCH_W), .MAT_W(MAT_W), .GAP_CYC(GAP_CYC)
`ifdef HPU_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) dut (
        .AXIS_ACLK   (clk),
        .AXIS_ARESETN(rst_n),
        .bus         (bus)
    );

    typedef struct {
        int ph;
        int beats_left;
        int gap_left;
        int batches;
        int src;
        int out;
        bit err;
        bit tmo;
        int wd;
    } model_t;

    model_t m;

    function automatic model_t mdl_zero();
        model_t z;
        z.ph = PH_IDLE; z.beats_left = 0; z.gap_left = 0; z.batches = 0;
        z.src = 0; z.out = 0; z.err = 1'b0; z.tmo = 1'b0; z.wd = 0;
        return z;
    endfunction

    // One cycle of job behaviour from the current inputs.
    function automatic model_t step(model_t c);
        model_t n;
        bit     kill;
`ifdef HPU_SCHED_TIMEOUT_EN
        bit     prog;
        bit     tmo_now;
`endif
        n     = c;
        n.err = 1'b0;
        kill  = bus.abort;
`ifdef HPU_SCHED_TIMEOUT_EN
        prog    = bus.mat_beat || bus.src_fin || bus.dst_last_hs;
        tmo_now = (c.ph == PH_LOAD || c.ph == PH_RUN) && !prog && (c.wd + 1 == TIMEOUT_CYC);
        kill    = kill || tmo_now;
`endif
        if (c.ph != PH_IDLE && kill) begin
            n.ph  = PH_IDLE;
            n.err = 1'b1;
`ifdef HPU_SCHED_TIMEOUT_EN
            if (tmo_now) n.tmo = 1'b1;
            n.wd = 0;
`endif
            return n;
        end
        if (c.ph != PH_IDLE && bus.start) n.err = 1'b1;
        case (c.ph)
            PH_IDLE: if (bus.start && !bus.abort) begin
                if (bus.cfg_batches == 0) n.err = 1'b1;
                else begin
                    n.batches = int'(bus.cfg_batches);
                    n.src = 0; n.out = 0; n.tmo = 1'b0;
                    if (bus.cfg_load_mat && bus.cfg_mat_words != 0) begin
                        n.ph = PH_LOAD; n.beats_left = int'(bus.cfg_mat_words);
                    end else begin
                        n.ph = PH_GAP; n.gap_left = GAP_CYC;
                    end
                end
            end
            PH_LOAD: if (bus.mat_beat) begin
                n.beats_left = c.beats_left - 1;
                if (n.beats_left == 0) begin n.ph = PH_GAP; n.gap_left = GAP_CYC; end
            end
            PH_GAP: begin
                n.gap_left = c.gap_left - 1;
                if (n.gap_left == 0) n.ph = PH_RUN;
            end
            PH_RUN: begin
                if (bus.src_fin && c.src < c.batches) n.src = c.src + 1;
                if (bus.dst_last_hs && c.out < c.batches) n.out = c.out + 1;
                if (n.out == c.batches) n.ph = PH_DONE;
            end
            default: n.ph = PH_IDLE;
        endcase
`ifdef HPU_SCHED_TIMEOUT_EN
        if (n.ph != c.ph || prog) n.wd = 0;
        else if (c.ph == PH_LOAD || c.ph == PH_RUN) n.wd = c.wd + 1;
`endif
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mdl_zero();
        else        m <= step(m);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("matw",    int'(bus.matw),    int'(m.ph == PH_LOAD));
            chk("run",     int'(bus.run),     int'(m.ph == PH_RUN));
            chk("last",    int'(bus.last),    int'(m.ph == PH_RUN && m.src >= m.batches - 1));
            chk("busy",    int'(bus.busy),    int'(m.ph != PH_IDLE));
            chk("done",    int'(bus.done),    int'(m.ph == PH_DONE));
            chk("err",     int'(bus.err),     int'(m.err));
            chk("src_cnt", int'(bus.src_cnt), m.src);
            chk("out_cnt", int'(bus.out_cnt), m.out);
`ifdef HPU_SCHED_TIMEOUT_EN
            chk("timeout_flag", int'(bus.timeout_flag), int'(m.tmo));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.start = 1'b0; bus.abort = 1'b0; bus.mat_beat = 1'b0;
        bus.src_fin = 1'b0; bus.dst_last_hs = 1'b0;
    endtask

    task automatic go(input bit load, input int words, input int batches);
        bus.cfg_load_mat  = load;
        bus.cfg_mat_words = MAT_W'(words);
        bus.cfg_batches   = BATCH_W'(batches);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        clr();
        bus.cfg_load_mat = 1'b0; bus.cfg_mat_words = '0; bus.cfg_batches = '0;
        repeat (3) tick();
        chk("rst_matw", int'(bus.matw), 0);
        chk("rst_run",  int'(bus.run),  0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err",  int'(bus.err),  0);
        chk("rst_src",  int'(bus.src_cnt), 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Load 100 words with two stall cycles, then three batches.
        go(1'b1, 100, 3);
        chk("t1_matw_first", int'(bus.matw), 1);
        mcyc = 0;
        for (int i = 0; i < 102; i++) begin
            bus.mat_beat = (i != 10 && i != 50);
            if (bus.matw) mcyc++;
            tick();
        end
        bus.mat_beat = 1'b0;
        chk("t1_matw_cycles", mcyc, 102);
        chk("t1_matw_drop", int'(bus.matw), 0);
        chk("t1_gap1_run", int'(bus.run), 0);
        tick();
        chk("t1_gap2_run", int'(bus.run), 0);
        tick();
        chk("t1_run_up", int'(bus.run), 1);
        chk("t1_last_lo", int'(bus.last), 0);
        bus.src_fin = 1'b1; tick(); clr();
        chk("t1_src1", int'(bus.src_cnt), 1);
        chk("t1_last_lo2", int'(bus.last), 0);
        bus.cfg_batches = BATCH_W'(7);
        bus.start = 1'b1; tick(); clr();
        chk("t1_busy_start_err", int'(bus.err), 1);
        chk("t1_busy_start_run", int'(bus.run), 1);
        bus.src_fin = 1'b1; bus.dst_last_hs = 1'b1; tick(); clr();
        chk("t1_last_up", int'(bus.last), 1);
        chk("t1_src2", int'(bus.src_cnt), 2);
        chk("t1_out1", int'(bus.out_cnt), 1);
        bus.src_fin = 1'b1; tick(); clr();
        bus.dst_last_hs = 1'b1; tick(); clr();
        chk("t1_no_early_done", int'(bus.done), 0);
        tick(); tick();
        bus.dst_last_hs = 1'b1; tick(); clr();
        chk("t1_done", int'(bus.done), 1);
        chk("t1_done_run", int'(bus.run), 0);
        chk("t1_src3", int'(bus.src_cnt), 3);
        chk("t1_out3", int'(bus.out_cnt), 3);
        tick();
        chk("t1_idle", int'(bus.busy), 0);
        chk("t1_hold_out", int'(bus.out_cnt), 3);

        // Run-only single batch.
        go(1'b0, 0, 1);
        chk("t2_matw", int'(bus.matw), 0);
        chk("t2_busy", int'(bus.busy), 1);
        tick();
        chk("t2_run_lo", int'(bus.run), 0);
        tick();
        chk("t2_run", int'(bus.run), 1);
        chk("t2_last", int'(bus.last), 1);
        bus.dst_last_hs = 1'b1; tick(); clr();
        chk("t2_done", int'(bus.done), 1);
        chk("t2_out", int'(bus.out_cnt), 1);
        tick();

        // Zero-batch start is rejected.
        go(1'b1, 5, 0);
        chk("t3_err", int'(bus.err), 1);
        chk("t3_busy", int'(bus.busy), 0);
        tick();
        chk("t3_err_clr", int'(bus.err), 0);

        // Abort part way through the matrix load.
        go(1'b1, 100, 2);
        bus.mat_beat = 1'b1;
        repeat (40) tick();
        bus.mat_beat = 1'b0;
        chk("t4_matw_mid", int'(bus.matw), 1);
        bus.abort = 1'b1; tick(); clr();
        chk("t4_matw", int'(bus.matw), 0);
        chk("t4_err", int'(bus.err), 1);
        chk("t4_busy", int'(bus.busy), 0);
        chk("t4_done", int'(bus.done), 0);
        tick();
        chk("t4_done2", int'(bus.done), 0);

        // Abort and start together during RUN.
        go(1'b0, 0, 2);
        tick(); tick();
        chk("t5_run", int'(bus.run), 1);
        bus.abort = 1'b1; bus.start = 1'b1; tick(); clr();
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_err", int'(bus.err), 1);
        tick();
        chk("t5_err_once", int'(bus.err), 0);
        chk("t5_stay_idle", int'(bus.busy), 0);

        // Coincident src/dst events, then reset mid-RUN.
        go(1'b0, 0, 2);
        tick(); tick();
        bus.src_fin = 1'b1; bus.dst_last_hs = 1'b1; tick(); clr();
        chk("t6_src", int'(bus.src_cnt), 1);
        chk("t6_out", int'(bus.out_cnt), 1);
        chk("t6_last", int'(bus.last), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_run",  int'(bus.run),  0);
        chk("t6_rst_last", int'(bus.last), 0);
        chk("t6_rst_busy", int'(bus.busy), 0);
        chk("t6_rst_done", int'(bus.done), 0);
        chk("t6_rst_src",  int'(bus.src_cnt), 0);
        chk("t6_rst_out",  int'(bus.out_cnt), 0);
        #1 rst_n = 1'b1;
        tick();

`ifdef HPU_SCHED_TIMEOUT_EN
        // Stalled RUN times out after TIMEOUT_CYC cycles.
        go(1'b0, 0, 2);
        tick(); tick();
        chk("t7_run", int'(bus.run), 1);
        repeat (TIMEOUT_CYC - 1) tick();
        chk("t7_run_hold", int'(bus.run), 1);
        tick();
        chk("t7_run_drop", int'(bus.run), 0);
        chk("t7_err", int'(bus.err), 1);
        chk("t7_flag", int'(bus.timeout_flag), 1);
        tick();
        chk("t7_flag_sticky", int'(bus.timeout_flag), 1);
        go(1'b0, 0, 1);
        chk("t7_flag_clr", int'(bus.timeout_flag), 0);
        tick(); tick();
        bus.dst_last_hs = 1'b1; tick(); clr();
        chk("t7_done", int'(bus.done), 1);
        tick();
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hpu_job_sched.md
Name: hpu_job_sched

Overview:
- Job-level sequencer for the HPU stream datapath, clocked on the AXI-Stream clock.
- Replaces direct software toggling of the matw/run/last control bits.
- Software posts one job descriptor (optional matrix load, batch count) plus a start pulse. The block then drives matw, run and last to the core/src/dst controllers, tracks per-batch input and output progress, and reports done/error.

Parameters:
- BATCH_W, 16, width of batch count and progress counters.
- MAT_W, 7, width of matrix-word count (up to 127 beats).
- GAP_CYC, 2, idle cycles with matw=0/run=0 between matrix load and run; min 1.

Ports:
- AXIS_ACLK  in  1  sole clock.
- AXIS_ARESETN  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job start pulse.
- abort  in  1  one-cycle abort pulse.
- cfg_load_mat  in  1  job includes a matrix load; sampled on accepted start.
- cfg_mat_words  in  MAT_W  matrix beats to load; sampled on start.
- cfg_batches  in  BATCH_W  number of src batches in the job; sampled on start.
- mat_beat  in  1  S_AXIS_TVALID & S_AXIS_TREADY while matw=1.
- src_fin  in  1  one-cycle pulse per completed src batch receive.
- dst_last_hs  in  1  M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST.
- matw  out  1  matrix-write enable to core/address counter.
- run  out  1  run enable; downstream controllers reset on ~run.
- last  out  1  final-batch flag.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on rejected start, abort or timeout.
- src_cnt  out  BATCH_W  batches received.
- out_cnt  out  BATCH_W  batches emitted.

Behaviour:
- Reset (async, AXIS_ARESETN=0): state=IDLE. matw, run, last, busy, done, err=0; src_cnt=out_cnt=0; latched config=0.
- States: IDLE, LOAD, GAP, RUN, DONE.
- IDLE:
  - start with cfg_batches!=0: latch config, clear src_cnt/out_cnt.
  - Go to LOAD if cfg_load_mat && cfg_mat_words!=0; otherwise go to GAP.
  - start with cfg_batches==0: err pulse next cycle, stay IDLE.
- LOAD:
  - matw=1 registered, starting the cycle after start.
  - Internal beat counter increments on mat_beat.
  - When mat_beat arrives with count==cfg_mat_words-1, matw drops next cycle and the block goes to GAP.
  - mat_beat outside LOAD is ignored.
- GAP: matw=0, run=0 for exactly GAP_CYC cycles, then go to RUN.
- RUN:
  - run=1 from the first RUN cycle.
  - src_fin increments src_cnt; dst_last_hs increments out_cnt; both saturate at cfg_batches.
  - last=1 from RUN entry if cfg_batches==1. Otherwise last rises in the cycle after the src_fin pulse that makes src_cnt==cfg_batches-1, and holds until run drops.
  - src_fin and dst_last_hs in the same cycle both count.
  - When out_cnt reaches cfg_batches (registered), go to DONE.
- DONE:
  - run and last drop in this cycle; done=1 for one cycle; next state IDLE; busy=0 from IDLE.
  - Counters hold their final values until the next accepted start.
- start while busy: ignored, err pulse, job unaffected.
- abort: in any non-IDLE state, go to IDLE next cycle with matw=run=last=0 and an err pulse; counters hold. abort in IDLE has no effect.
- start and abort in the same cycle: abort wins; start is discarded with no extra err.
- Reset mid-job: immediate return to reset values; no done pulse.
- Latency: start to first matw=1 is 1 cycle. Last load beat to run=1 is GAP_CYC+1 cycles. Final dst_last_hs to done is 1 cycle.

Optional Feature:
- Macro HPU_SCHED_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 65535) and a progress watchdog.
  - The watchdog counter clears on any mat_beat, src_fin or dst_last_hs, and on state change.
  - It increments in LOAD and RUN.
  - On reaching TIMEOUT_CYC it behaves exactly like abort, and a sticky output timeout_flag (1 bit) is set; the flag clears on the next accepted start.
- Undefined: no counter, no timeout_flag port; the block waits indefinitely.

Test Plan:
- Load+run: cfg_load_mat=1, mat_words=100, batches=3, start.
  - matw high for exactly 100 mat_beats, then low 2 cycles, then run=1.
  - last rises after the 2nd src_fin.
  - done 1 cycle after the 3rd dst_last_hs; src_cnt=out_cnt=3.
- Run-only single batch: cfg_load_mat=0, batches=1. matw never rises; run and last both high 3 cycles after start (1 + GAP_CYC); done after one dst_last_hs.
- Rejects: start with batches=0 gives an err pulse and stays IDLE. A second start during RUN gives an err pulse and the job still completes with original counts.
- Abort: abort during LOAD after 40 beats gives matw=0 next cycle, an err pulse and IDLE; no done pulse. Abort+start in the same cycle during RUN gives IDLE and a single err.
- Simultaneous events (batches=2): src_fin and dst_last_hs in the same cycle increment both counters; reset asserted mid-RUN forces all outputs to 0 asynchronously.
- With HPU_SCHED_TIMEOUT_EN and TIMEOUT_CYC=50: no src_fin for 50 RUN cycles gives run=0, an err pulse and timeout_flag=1; the next start clears the flag.
